sorteio_papeis: RTL
===================

Name: sorteio_papeis

Overview:
- Downstream of the game control unit. Latches the game seed when the controller pulses e_seed_reg, then runs an LFSR-driven Fisher-Yates shuffle on start.
- The shuffle assigns one role (villager, werewolf, seer) to each player slot.
- Result is held in a role register array, readable by player index, until the next draw or global reset.

Parameters:
- N_JOGADORES, 8, number of player slots (2..16).
- N_LOBOS, 2, werewolf count (1..N_JOGADORES-2).
- N_VIDENTES, 1, seer count (0..N_JOGADORES-N_LOBOS-1).
- W_SEED, 16, seed/LFSR width (fixed 16 in this revision).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rst_global  in  1  synchronous clear from the control unit, active-high.
- e_seed_reg  in  1  seed load enable, one-cycle pulse.
- seed_in  in  16  seed value, sampled when e_seed_reg=1.
- inicia  in  1  start draw, one-cycle pulse.
- idx_jogador  in  W_IDX  read index, W_IDX=$clog2(N_JOGADORES).
- papel  out  2  role of slot idx_jogador, combinational read: 0=ALDEAO, 1=LOBO, 2=VIDENTE.
- ocupado  out  1  draw in progress.
- pronto  out  1  high while a valid assignment is held.
- fim_sorteio  out  1  one-cycle pulse when a draw completes.
- db_estado  out  3  current FSM state code.

Behaviour:
- reset low (async) and rst_global high (sync) have identical effect:
  - state OCIOSO, lfsr=16'hACE1, all roles ALDEAO, i=0, j=0.
  - ocupado=0, pronto=0, fim_sorteio=0.
- LFSR: Fibonacci, taps 16,14,13,11. Shift-in bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], shifted into bit 0. Advances only in SORTEIA.
- Seed load:
  - When e_seed_reg=1 in OCIOSO or PRONTO, lfsr<=seed_in.
  - If seed_in==0, lfsr<=16'hACE1 instead (avoids lock-up).
  - e_seed_reg is ignored in CARREGA/SORTEIA/TROCA.
- FSM states (db_estado code):
  - OCIOSO(0): inicia -> CARREGA.
  - CARREGA(1): one cycle. Slots 0..N_LOBOS-1=LOBO, next N_VIDENTES slots=VIDENTE, rest ALDEAO. i<=N_JOGADORES-1. -> SORTEIA.
  - SORTEIA(2): j_cand=lfsr[W_IDX-1:0]; lfsr advances every cycle here.
    - If j_cand<=i: j<=j_cand, -> TROCA.
    - Else stay (rejection retry, one cycle each).
  - TROCA(3): swap role[i] and role[j] (no-op if i==j).
    - If i==1: -> PRONTO, fim_sorteio=1 this cycle.
    - Else i<=i-1, -> SORTEIA.
  - PRONTO(4): holds result. inicia -> CARREGA (redraw continues from current lfsr).
  - Codes 5..7 unreachable; recover to OCIOSO next cycle.
- Outputs:
  - ocupado=1 in CARREGA, SORTEIA, TROCA.
  - pronto=1 only in PRONTO; it drops when a redraw starts.
  - papel valid only while pronto=1. It still reflects raw array contents at other times.
- inicia during CARREGA/SORTEIA/TROCA is ignored.
- inicia and e_seed_reg in the same cycle (OCIOSO/PRONTO): seed loads, and the draw starts the next cycle using the new seed.
- rst_global mid-draw aborts immediately to the reset values; no fim_sorteio.
- idx_jogador >= N_JOGADORES: papel=ALDEAO.
- Invariant: after every draw, exactly N_LOBOS LOBO and N_VIDENTES VIDENTE entries.
- Latency: 1 + sum over i of (retries+1) + (N_JOGADORES-1) TROCA cycles. Deterministic for a given seed.

Optional Feature:
- SORTEIO_DEBUG_EN defined:
  - adds outputs db_lfsr[15:0] (current LFSR) and db_tentativas[7:0].
  - db_tentativas counts rejection cycles in the current draw, saturating at 255, cleared in CARREGA.
- Undefined: ports and counter absent; functional behaviour identical.

Decomposition:
- Package lobinho_pkg:
  - role encodings ALDEAO/LOBO/VIDENTE.
  - state codes.
  - LFSR_DEFAULT=16'hACE1.
  - LFSR tap constants.
- Sub-module lfsr16 (enable, load, load_value, q); zero-seed substitution stays in the parent.
- Role array and FSM live in sorteio_papeis.

Test Plan:
- Reset low mid-run, then release -> db_estado=0, pronto=0, all 8 papel reads=0, lfsr=0xACE1 (debug build).
- e_seed_reg with seed_in=0x0000, then inicia -> identical papel vector to seed 0xACE1; fim_sorteio pulses exactly once; ocupado low afterwards.
- Seeds 0x0001, 0x1234, 0xFFFF -> papel vector and latency match the bench golden model bit-exactly; each has 2 LOBO, 1 VIDENTE.
- Same seed 0x1234 loaded twice with a draw after each -> identical vectors. Redraw from PRONTO without reload -> matches model continuing from the post-draw lfsr.
- inicia pulsed during SORTEIA and e_seed_reg=0xBEEF during TROCA -> both ignored; result equals the unperturbed 0x1234 draw.
- rst_global asserted in the third TROCA cycle -> next cycle OCIOSO, roles all ALDEAO, no fim_sorteio; idx_jogador=9 (N=8, W_IDX=4 variant) -> papel=0.

Source files
------------

// File: rtl/lobinho_pkg.sv
// Shared encodings for the role draw: player roles, draw FSM codes and LFSR constants.
package lobinho_pkg;

  typedef enum logic [1:0] {
    ALDEAO  = 2'd0,
    LOBO    = 2'd1,
    VIDENTE = 2'd2
  } papel_t;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    SORTEIA = 3'd2,
    TROCA   = 3'd3,
    PRONTO  = 3'd4
  } estado_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  function automatic logic lfsr_feedback(input logic [15:0] v);
    return v[LFSR_TAP_A] ^ v[LFSR_TAP_B] ^ v[LFSR_TAP_C] ^ v[LFSR_TAP_D];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous clear and load; shifts left, feedback into bit 0.
// q exposes only the low W_Q bits the parent actually consumes.
module lfsr16
  import lobinho_pkg::*;
#(
  parameter int W_Q = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic            load,
  input  logic [15:0]     load_value,
  output logic [W_Q-1:0]  q
);

  logic [15:0] estado_lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_lfsr <= LFSR_DEFAULT;
    end else if (clear) begin
      estado_lfsr <= LFSR_DEFAULT;
    end else if (load) begin
      estado_lfsr <= load_value;
    end else if (enable) begin
      estado_lfsr <= {estado_lfsr[14:0], lfsr_feedback(estado_lfsr)};
    end
  end

  assign q = estado_lfsr[W_Q-1:0];

endmodule

// File: rtl/sorteio_papeis.sv
// Role draw: latches a seed, then Fisher-Yates shuffles LOBO/VIDENTE/ALDEAO over the player slots.
// Optional SORTEIO_DEBUG_EN adds db_lfsr and db_tentativas (saturating rejection count per draw).
module sorteio_papeis
  import lobinho_pkg::*;
#(
  parameter int N_JOGADORES = 8,
  parameter int N_LOBOS     = 2,
  parameter int N_VIDENTES  = 1,
  parameter int W_SEED      = 16,
  parameter int W_IDX       = $clog2(N_JOGADORES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rst_global,
  input  logic              e_seed_reg,
  input  logic [W_SEED-1:0] seed_in,
  input  logic              inicia,
  input  logic [W_IDX-1:0]  idx_jogador,
  output logic [1:0]        papel,
  output logic              ocupado,
  output logic              pronto,
  output logic              fim_sorteio,
  output logic [2:0]        db_estado
`ifdef SORTEIO_DEBUG_EN
  ,
  output logic [15:0]       db_lfsr,
  output logic [7:0]        db_tentativas
`endif
);

`ifdef SORTEIO_DEBUG_EN
  localparam int W_LFSR_Q = 16;
`else
  localparam int W_LFSR_Q = W_IDX;
`endif

  estado_t              estado, estado_nxt;
  papel_t               roles [N_JOGADORES];
  logic [W_IDX-1:0]     i, j;
  logic [W_LFSR_Q-1:0]  lfsr_q;
  logic [W_IDX-1:0]     j_cand;
  logic                 aceita;
  logic                 ultimo;
  logic                 lfsr_en, lfsr_ld;
  logic [15:0]          lfsr_ld_val;
  papel_t               role_i, role_j, papel_sel;

  lfsr16 #(.W_Q(W_LFSR_Q)) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .clear      (rst_global),
    .enable     (lfsr_en),
    .load       (lfsr_ld),
    .load_value (lfsr_ld_val),
    .q          (lfsr_q)
  );

  assign j_cand      = lfsr_q[W_IDX-1:0];
  assign aceita      = (j_cand <= i);
  assign ultimo      = (i == W_IDX'(1));
  assign lfsr_en     = (estado == SORTEIA);
  assign lfsr_ld     = e_seed_reg && ((estado == OCIOSO) || (estado == PRONTO));
  // an all-zero seed would freeze the LFSR
  assign lfsr_ld_val = (seed_in == '0) ? LFSR_DEFAULT : seed_in;

  // Index muxes written as loops so any index width (including out of range) decodes safely
  always_comb begin
    role_i    = ALDEAO;
    role_j    = ALDEAO;
    papel_sel = ALDEAO;
    for (int k = 0; k < N_JOGADORES; k++) begin
      if (i == W_IDX'(k))           role_i    = roles[k];
      if (j == W_IDX'(k))           role_j    = roles[k];
      if (idx_jogador == W_IDX'(k)) papel_sel = roles[k];
    end
  end

  assign papel     = papel_sel;
  assign db_estado = estado;

  always_comb begin
    estado_nxt  = estado;
    ocupado     = 1'b0;
    pronto      = 1'b0;
    fim_sorteio = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicia) estado_nxt = CARREGA;
      end
      CARREGA: begin
        ocupado    = 1'b1;
        estado_nxt = SORTEIA;
      end
      SORTEIA: begin
        ocupado = 1'b1;
        if (aceita) estado_nxt = TROCA;
      end
      TROCA: begin
        ocupado = 1'b1;
        if (ultimo) begin
          estado_nxt  = PRONTO;
          fim_sorteio = 1'b1;
        end else begin
          estado_nxt = SORTEIA;
        end
      end
      PRONTO: begin
        pronto = 1'b1;
        if (inicia) estado_nxt = CARREGA;
      end
      default: estado_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      i      <= '0;
      j      <= '0;
      for (int k = 0; k < N_JOGADORES; k++) roles[k] <= ALDEAO;
    end else if (rst_global) begin
      estado <= OCIOSO;
      i      <= '0;
      j      <= '0;
      for (int k = 0; k < N_JOGADORES; k++) roles[k] <= ALDEAO;
    end else begin
      estado <= estado_nxt;
      case (estado)
        CARREGA: begin
          i <= W_IDX'(N_JOGADORES - 1);
          for (int k = 0; k < N_JOGADORES; k++) begin
            roles[k] <= (k < N_LOBOS) ? LOBO :
                        (k < N_LOBOS + N_VIDENTES) ? VIDENTE : ALDEAO;
          end
        end
        SORTEIA: begin
          if (aceita) j <= j_cand;
        end
        TROCA: begin
          for (int k = 0; k < N_JOGADORES; k++) begin
            if (i == W_IDX'(k))      roles[k] <= role_j;
            else if (j == W_IDX'(k)) roles[k] <= role_i;
          end
          if (!ultimo) i <= i - W_IDX'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SORTEIO_DEBUG_EN
  logic [7:0] tentativas;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tentativas <= '0;
    end else if (rst_global || (estado == CARREGA)) begin
      tentativas <= '0;
    end else if ((estado == SORTEIA) && !aceita && (tentativas != 8'hFF)) begin
      tentativas <= tentativas + 8'd1;
    end
  end

  assign db_lfsr       = lfsr_q;
  assign db_tentativas = tentativas;
`endif

endmodule
